// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin arbitration between core and debug ports onto one word memory,
// with sub-word loads/stores via read-modify-write. Optional misalign trap: DMEM_CTRL_MISALIGN_TRAP_EN.
module dmem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_we,
  input  logic [1:0]  core_size,
  input  logic        core_unsigned,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic        core_gnt,
  output logic        core_rvalid,
  output logic        core_err,
  output logic [31:0] core_rdata,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WRITE, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_dbg;
  logic        w_gnt_core;
  logic        w_gnt_dbg;
  logic        w_gnt;
  logic        w_misalign;
  logic        w_resp;
  logic        w_mem_w_en;
  logic [31:0] w_mem_addr;
  logic [31:0] w_mem_w_data;

  logic        r_dbg_p1;
  logic        r_we_p1;
  logic        r_uns_p1;
  logic [1:0]  r_size_p1;
  logic [31:0] r_addr_p1;
  logic [31:0] r_wdata_p1;
  logic [31:0] r_rdata_p2;
  logic [31:0] r_merge_p2;

  function automatic logic [31:0] f_load_ext(input logic [31:0] word, input logic [1:0] lane,
                                             input logic [1:0] size, input logic uns);
    logic signed [7:0]  v_b;
    logic signed [15:0] v_h;
    logic [31:0]        v_out;
    v_b = $signed(word[{lane, 3'b000} +: 8]);
    v_h = $signed(word[{lane[1], 4'b0000} +: 16]);
    case (size)
      2'b00:   v_out = uns ? {24'd0, v_b} : 32'(v_b);
      2'b01:   v_out = uns ? {16'd0, v_h} : 32'(v_h);
      default: v_out = word;
    endcase
    return v_out;
  endfunction

  function automatic logic [31:0] f_store_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] lane, input logic [1:0] size);
    logic [31:0] v_out;
    v_out = old;
    if (size == 2'b00) v_out[{lane, 3'b000} +: 8] = wd[7:0];
    else               v_out[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return v_out;
  endfunction

  // Arbitration: ties go to the port that was not granted last.
  always_comb begin
    w_gnt_core = 1'b0;
    w_gnt_dbg  = 1'b0;
    if (!rst && r_state == S_IDLE) begin
      if (core_req && dbg_req) begin
        w_gnt_core = r_last_dbg;
        w_gnt_dbg  = !r_last_dbg;
      end else begin
        w_gnt_core = core_req;
        w_gnt_dbg  = dbg_req;
      end
    end
  end

  assign w_gnt    = w_gnt_core | w_gnt_dbg;
  assign core_gnt = w_gnt_core;
  assign dbg_gnt  = w_gnt_dbg;

`ifdef DMEM_CTRL_MISALIGN_TRAP_EN
  logic r_err_p1;
  assign w_misalign = w_gnt_core &&
                      ((core_size == 2'b01 && core_addr[0]) ||
                       (core_size[1] && core_addr[1:0] != 2'b00));
  always_ff @(posedge clk) begin
    if (w_gnt) r_err_p1 <= w_misalign;
  end
  assign core_err = core_rvalid & r_err_p1;
`else
  assign w_misalign = 1'b0;
  assign core_err   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_dbg <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      if (w_gnt) r_last_dbg <= w_gnt_dbg;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_mem_w_en   = 1'b0;
    w_mem_addr   = '0;
    w_mem_w_data = '0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) w_state_nxt = w_misalign ? S_RESP : S_EXEC;
      end
      S_EXEC: begin
        w_mem_addr = {r_addr_p1[31:2], 2'b00};
        if (r_we_p1 && !r_size_p1[1]) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_RESP;
        end
        if (r_we_p1 && r_size_p1[1]) begin
          w_mem_w_en   = 1'b1;
          w_mem_w_data = r_wdata_p1;
        end
      end
      S_WRITE: begin
        w_mem_addr   = {r_addr_p1[31:2], 2'b00};
        w_mem_w_en   = 1'b1;
        w_mem_w_data = r_merge_p2;
        w_state_nxt  = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A reset edge aborts the transaction, so the write strobe is suppressed while rst is high.
  assign mem_w_en   = w_mem_w_en & ~rst;
  assign mem_addr   = w_mem_addr;
  assign mem_w_data = w_mem_w_data;

  // Stage p1: request fields captured on the grant edge (debug is always a full word).
  // Stage p2: load result / merged store word captured at the end of EXEC.
  always_ff @(posedge clk) begin
    if (w_gnt) begin
      r_dbg_p1   <= w_gnt_dbg;
      r_we_p1    <= w_gnt_dbg ? dbg_we : core_we;
      r_size_p1  <= w_gnt_dbg ? 2'b10 : core_size;
      r_uns_p1   <= w_gnt_dbg ? 1'b0 : core_unsigned;
      r_addr_p1  <= w_gnt_dbg ? dbg_addr : core_addr;
      r_wdata_p1 <= w_gnt_dbg ? dbg_wdata : core_wdata;
      r_rdata_p2 <= '0;
    end else if (r_state == S_EXEC) begin
      if (!r_we_p1) r_rdata_p2 <= f_load_ext(mem_r_data, r_addr_p1[1:0], r_size_p1, r_uns_p1);
      r_merge_p2 <= f_store_merge(mem_r_data, r_wdata_p1, r_addr_p1[1:0], r_size_p1);
    end
  end

  assign w_resp      = (r_state == S_RESP) && !rst;
  assign core_rvalid = w_resp & ~r_dbg_p1;
  assign dbg_rvalid  = w_resp & r_dbg_p1;
  assign core_rdata  = core_rvalid ? r_rdata_p2 : '0;
  assign dbg_rdata   = dbg_rvalid ? r_rdata_p2 : '0;

endmodule
